// File: rtl/text_render_pkg.sv
// ============================================================================
//  Module : text_render_pkg
//  Shared constants for the character-mode tile renderer.
//  Macro  : TEXT_RENDER_ATTR_EN widens text RAM words to carry fg/bg colour.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package text_render_pkg;

  localparam int TILE_W      = 8;
  localparam int FONT_ADDR_W = 11;
  localparam int CHAR_W      = 8;
  localparam int COLOR_W     = 4;

  // Attribute byte sits above the character code; fg in its low nibble.
  localparam int ATTR_LSB    = 8;
  localparam int ATTR_W      = 8;
  localparam int ATTR_FG_OFS = 0;
  localparam int ATTR_BG_OFS = 4;

`ifdef TEXT_RENDER_ATTR_EN
  localparam int TEXT_W = CHAR_W + ATTR_W;
`else
  localparam int TEXT_W = CHAR_W;
`endif

  localparam logic [2:0] PH_ADDR  = 3'd1;
  localparam logic [2:0] PH_LATCH = 3'd3;
  localparam logic [2:0] PH_LOAD  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/tile_fetch.sv
// ============================================================================
//  Module : tile_fetch
//  Next-tile address generation, text RAM / glyph ROM fetch and pending latch.
//  Macro  : TEXT_RENDER_ATTR_EN adds the pending attribute latch.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tile_fetch
  import text_render_pkg::*;
#(
  parameter int COLS    = 32,
  parameter int ROWS    = 30,
  parameter int H_TOTAL = 320,
  parameter int V_TOTAL = 262,
  parameter int ADDR_W  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  output logic [ADDR_W-1:0]      text_addr,
  input  logic [TEXT_W-1:0]      text_data,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
`ifdef TEXT_RENDER_ATTR_EN
  output logic [ATTR_W-1:0]      pending_attr,
`endif
  output logic [7:0]             pending
);

  localparam logic [6:0] c_cols   = 7'(COLS);
  localparam logic [6:0] c_rows   = 7'(ROWS);
  localparam logic [9:0] c_h_wrap = 10'(H_TOTAL - TILE_W);
  localparam logic [9:0] c_v_last = 10'(V_TOTAL - 1);

  logic [2:0]        w_phase;
  logic              w_wrap;
  logic [6:0]        w_ncol;
  logic [9:0]        w_nline;
  logic [6:0]        w_nrow;
  logic              w_blank;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_text_addr;
  logic [2:0]        r_fetch_y;
  logic              r_blank;
  logic              r_primed;
  logic [7:0]        r_pending;

  assign w_phase = hpos[2:0];
  assign w_wrap  = (hpos >= c_h_wrap);
  assign w_ncol  = w_wrap ? 7'd0 : (hpos[9:3] + 7'd1);
  assign w_nline = !w_wrap ? vpos : ((vpos >= c_v_last) ? 10'd0 : (vpos + 10'd1));
  assign w_nrow  = w_nline[9:3];
  assign w_blank = (w_ncol >= c_cols) || (w_nrow >= c_rows);
  assign w_addr  = ADDR_W'(w_nrow) * ADDR_W'(COLS) + ADDR_W'(w_ncol);

  // r_primed keeps the tile already in flight at reset release blank, even
  // though the cleared blank flag would otherwise let RAM word 0 through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_text_addr <= '0;
      r_fetch_y   <= '0;
      r_blank     <= 1'b0;
      r_primed    <= 1'b0;
      r_pending   <= '0;
    end else begin
      if (w_phase == PH_ADDR) begin
        r_fetch_y <= w_nline[2:0];
        r_blank   <= w_blank;
        r_primed  <= 1'b1;
        if (!w_blank) r_text_addr <= w_addr;
      end
      if (w_phase == PH_LATCH)
        r_pending <= (r_blank || !r_primed) ? 8'h00 : font_data;
    end
  end

`ifdef TEXT_RENDER_ATTR_EN
  logic [ATTR_W-1:0] r_pending_attr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pending_attr <= '0;
    else if (w_phase == PH_LATCH)
      r_pending_attr <= (r_blank || !r_primed) ? '0 : text_data[ATTR_LSB +: ATTR_W];
  end

  assign pending_attr = r_pending_attr;
`endif

  assign text_addr = r_text_addr;
  assign font_addr = {text_data[CHAR_W-1:0], r_fetch_y};
  assign pending   = r_pending;

endmodule

`default_nettype wire

// File: rtl/text_tile_renderer.sv
// ============================================================================
//  Module : text_tile_renderer
//  8x8 glyph text renderer: prefetches the next tile, shifts pixels to rgb.
//  Macro  : TEXT_RENDER_ATTR_EN enables per-character fg/bg attributes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_tile_renderer
  import text_render_pkg::*;
#(
  parameter int           COLS     = 32,
  parameter int           ROWS     = 30,
  parameter int           H_TOTAL  = 320,
  parameter int           V_TOTAL  = 262,
  parameter int           ADDR_W   = 10,
  parameter logic [3:0]   FG_COLOR = 4'hF,
  parameter logic [3:0]   BG_COLOR = 4'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   display_on,
  output logic [ADDR_W-1:0]      text_addr,
  input  logic [TEXT_W-1:0]      text_data,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  output logic [COLOR_W-1:0]     rgb
);

  logic [TILE_W-1:0]  w_pending;
  logic [TILE_W-1:0]  r_shreg;
  logic [COLOR_W-1:0] w_fg;
  logic [COLOR_W-1:0] w_bg;

`ifdef TEXT_RENDER_ATTR_EN
  logic [ATTR_W-1:0]  w_pending_attr;
  logic [ATTR_W-1:0]  r_attr;
`endif

  tile_fetch #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .ADDR_W  (ADDR_W)
  ) u_tile_fetch (
    .clk          (clk),
    .reset        (reset),
    .hpos         (hpos),
    .vpos         (vpos),
    .text_addr    (text_addr),
    .text_data    (text_data),
    .font_addr    (font_addr),
    .font_data    (font_data),
`ifdef TEXT_RENDER_ATTR_EN
    .pending_attr (w_pending_attr),
`endif
    .pending      (w_pending)
  );

  // The load on the last phase makes the glyph MSB visible exactly at phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_shreg <= '0;
    else if (hpos[2:0] == PH_LOAD)
      r_shreg <= w_pending;
    else
      r_shreg <= r_shreg << 1;
  end

`ifdef TEXT_RENDER_ATTR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_attr <= '0;
    else if (hpos[2:0] == PH_LOAD)
      r_attr <= w_pending_attr;
  end

  assign w_fg = r_attr[ATTR_FG_OFS +: COLOR_W];
  assign w_bg = r_attr[ATTR_BG_OFS +: COLOR_W];
`else
  assign w_fg = FG_COLOR;
  assign w_bg = BG_COLOR;
`endif

  assign rgb = display_on ? (r_shreg[TILE_W-1] ? w_fg : w_bg) : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_text_tile_renderer.sv
// ============================================================================
//  Module : tb_text_tile_renderer
//  Randomised bench for text_tile_renderer against a screen-level model.
//  Macro  : TEXT_RENDER_ATTR_EN selects the 16-bit attribute build.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_text_tile_renderer;

  localparam int COLS    = 32;
  localparam int ROWS    = 30;
  localparam int H_TOTAL = 320;
  localparam int V_TOTAL = 262;
  localparam logic [3:0] FG_COLOR = 4'hF;
  localparam logic [3:0] BG_COLOR = 4'h0;
`ifdef TEXT_RENDER_ATTR_EN
  localparam int DW = 16;
`else
  localparam int DW = 8;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    hpos, vpos;
  logic          display_on;
  logic [9:0]    text_addr;
  logic [DW-1:0] text_data;
  logic [10:0]   font_addr;
  logic [7:0]    font_data;
  logic [3:0]    rgb;

  logic [DW-1:0] ram  [0:1023];
  logic [7:0]    font [0:2047];

  int total = 0;
  int bad   = 0;
  int since_jump = 0;
  int don_mode   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) text_data <= ram[text_addr];
  assign font_data = font[font_addr];

  text_tile_renderer #(
    .COLS(COLS), .ROWS(ROWS), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .ADDR_W(10), .FG_COLOR(FG_COLOR), .BG_COLOR(BG_COLOR)
  ) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .text_addr(text_addr), .text_data(text_data), .font_addr(font_addr),
    .font_data(font_data), .rgb(rgb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s hpos=%0d vpos=%0d got=%0h expected=%0h", tag, hpos, vpos, got, exp);
    end
  endtask

  function automatic logic [3:0] blank_rgb(input logic don);
    if (!don) return 4'h0;
`ifdef TEXT_RENDER_ATTR_EN
    return 4'h0;
`else
    return BG_COLOR;
`endif
  endfunction

  // What the screen should show at (h, v): the glyph bit of the character cell.
  function automatic logic [3:0] model_rgb(input int h, input int v, input logic don);
    int col, row, idx;
    logic [DW-1:0] w;
    logic [7:0] g;
    logic [3:0] fg, bg;
    col = h / 8;
    row = v / 8;
    if (!don || col >= COLS || row >= ROWS) return blank_rgb(don);
    w   = ram[row * COLS + col];
    idx = int'(w[7:0]) * 8 + (v % 8);
    g   = font[idx];
`ifdef TEXT_RENDER_ATTR_EN
    fg = w[11:8];
    bg = w[15:12];
`else
    fg = FG_COLOR;
    bg = BG_COLOR;
`endif
    return g[7 - (h % 8)] ? fg : bg;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
    if (hpos == 10'(H_TOTAL - 1)) begin
      hpos = 0;
      vpos = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
    case (don_mode)
      0: display_on = 1'b1;
      1: display_on = ($urandom_range(0, 7) != 0);
      default: display_on = 1'b0;
    endcase
    since_jump++;
  endtask

  task automatic jump(input int h, input int v);
    hpos = 10'(h);
    vpos = 10'(v);
    since_jump = 0;
  endtask

  // One checked cycle: pixel, next-tile fetch address, and the held blank-time address.
  task automatic step();
    int ncol, nline, h, v;
    logic [DW-1:0] w;
    @(negedge clk);
    h = int'(hpos);
    v = int'(vpos);
    if (since_jump >= 16) begin
      check("rgb", 32'(rgb), 32'(model_rgb(h, v, display_on)));
      ncol  = h / 8 + 1;
      nline = v;
      if (h >= H_TOTAL - 8) begin
        ncol  = 0;
        nline = (v + 1) % V_TOTAL;
      end
      if (ncol < COLS && nline / 8 < ROWS) begin
        if (h % 8 >= 2) check("text_addr", 32'(text_addr), 32'((nline / 8) * COLS + ncol));
        if (h % 8 == 3) begin
          w = ram[(nline / 8) * COLS + ncol];
          check("font_addr", 32'(font_addr), 32'({w[7:0], 3'(nline % 8)}));
        end
      end
    end
    if (since_jump >= 80 && v < ROWS * 8 && h >= 256 && h < 312)
      check("hold_addr", 32'(text_addr), 32'((v / 8) * COLS + COLS - 1));
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int h, input int v);
    int budget;
    budget = H_TOTAL * 4;
    while (!(int'(hpos) == h && int'(vpos) == v) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("FAIL run_to timeout target=%0d,%0d at hpos=%0d vpos=%0d", h, v, hpos, vpos);
    end
  endtask

  initial begin
    logic [3:0] afg, abg, exp_px;
    for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom);
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
`ifdef TEXT_RENDER_ATTR_EN
    ram[0] = DW'(16'h1241);
    afg = 4'h2;
    abg = 4'h1;
`else
    ram[0] = DW'(8'h41);
    afg = FG_COLOR;
    abg = BG_COLOR;
`endif
    font[11'h208] = 8'h30;

    reset = 1'b1;
    hpos = 0;
    vpos = 0;
    display_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rgb_on", 32'(rgb), 32'(blank_rgb(1'b1)));
    check("rst_addr", 32'(text_addr), 32'd0);
    display_on = 1'b0;
    #1;
    check("rst_rgb_off", 32'(rgb), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    display_on = 1'b1;

    // Character 'A' at the top-left cell, fetched across the frame wrap.
    jump(296, V_TOTAL - 1);
    run_to(0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_px = (i == 2 || i == 3) ? afg : abg;
      check("glyph_A", 32'(rgb), 32'(exp_px));
      advance();
    end

    // Row boundary: fetch of row 1 at the end of line 7.
    jump(296, 7);
    run_to(16, 8);

    // Reset pulse mid-line.
    don_mode = 1;
    jump(40, 20);
    run_to(100, 20);
    reset = 1'b1;
    while (hpos != 10'd197) begin
      @(negedge clk);
      check("rst_mid_rgb", 32'(rgb), 32'(blank_rgb(display_on)));
      check("rst_mid_addr", 32'(text_addr), 32'd0);
      advance();
    end
    reset = 1'b0;
    while (hpos != 10'd208) begin
      @(negedge clk);
      check("rst_blank_tile", 32'(rgb), 32'(blank_rgb(display_on)));
      advance();
    end
    since_jump = 1000;
    run(200);

    // Random positions and display_on patterns.
    for (int k = 0; k < 6; k++) begin
      jump($urandom_range(0, H_TOTAL - 1), $urandom_range(0, V_TOTAL - 1));
      run(600);
    end

    // display_on low across visible glyphs.
    don_mode = 2;
    jump(0, 30);
    run(400);

    // Rows at and beyond ROWS must stay background even with solid glyphs.
    don_mode = 0;
    for (int i = 0; i < 1024; i++) ram[i] = DW'({8'($urandom), 8'hDB});
    for (int y = 0; y < 8; y++) font[8'hDB * 8 + y] = 8'hFF;
    jump(296, ROWS * 8 - 1);
    run_to(40, ROWS * 8 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_tile_renderer.md
Name: text_tile_renderer

Overview:
- Character-mode video renderer; the consumer side of the 8x8 CP437 glyph ROM interface.
- Reads character codes from an external text RAM, indexes the glyph ROM with {char_id, y}, and serialises each 8-pixel glyph row to a colour output.
- Sits between the hvsync timing generator (hpos/vpos/display_on) and the video output mux.
- Prefetches the next tile during the current one, so pixel output has zero latency relative to hpos.

Parameters:
- COLS, 32, text columns.
- ROWS, 30, text rows.
- H_TOTAL, 320, total hpos count per line, including blanking.
- V_TOTAL, 262, total vpos count per frame.
- ADDR_W, 10, text RAM address width.
- FG_COLOR, 4'hF, foreground colour (ATTR_EN off).
- BG_COLOR, 4'h0, background colour (ATTR_EN off).

Ports:
- clk  in  1  system clock, one pixel per cycle.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  10  current pixel x from the timing generator.
- vpos  in  10  current line y.
- display_on  in  1  visible-area flag.
- text_addr  out  ADDR_W  text RAM address, registered.
- text_data  in  8 (16 with ATTR_EN)  text RAM read data; synchronous RAM, valid the cycle after text_addr is sampled.
- font_addr  out  11  glyph ROM address {char_id[7:0], y[2:0]}.
- font_data  in  8  glyph ROM row, combinational; MSB is the leftmost pixel.
- rgb  out  4  pixel colour.

Behaviour:
- Phase p = hpos[2:0]. Each tile is 8 phases; the fetch pipeline works on the NEXT tile.
- Edge ending phase 1:
  - ncol = hpos[9:3]+1; nline = vpos.
  - If hpos >= H_TOTAL-8: ncol=0 and nline = vpos+1, wrapping to 0 at V_TOTAL.
  - Register text_addr = (nline>>3)*COLS + ncol; register fetch_y = nline[2:0].
  - Register blank = (ncol >= COLS) || ((nline>>3) >= ROWS).
  - When blank, text_addr holds its previous value.
- Phase 2: RAM samples text_addr at the edge ending phase 2.
- Phase 3: text_data is valid. font_addr = {text_data[7:0], fetch_y}, combinational from text_data.
- Edge ending phase 3: pending <= blank ? 8'h00 : font_data. With ATTR_EN, attr is latched here too.
- Edge ending phase 7: shreg <= pending; active attr <= pending attr.
- Edges ending phases 0-6: shreg <= shreg << 1.
- Output: rgb = display_on ? (shreg[7] ? fg : bg) : 4'h0.
  - Combinational from registers and display_on.
  - The pixel for hpos appears in the same cycle.
- Font_addr outside phase 3 is don't-care, but must remain a function of registered state and text_data only.
- Async reset clears text_addr, fetch_y, blank, pending, shreg and attr registers to 0.
  - rgb = BG_COLOR if display_on, else 0.
  - A tile in flight when reset deasserts renders blank. Correct glyphs resume from the first tile whose phase-1 edge follows the release.
- hpos discontinuity (e.g. a timing-generator reset): the pipeline self-recovers within one tile. No other error state exists.

Optional Feature:
- TEXT_RENDER_ATTR_EN defined:
  - text_data is 16 bits: [7:0] char, [11:8] fg, [15:12] bg.
  - Attr is pipelined alongside the glyph.
  - Blank tiles use attr 0.
- Not defined:
  - text_data is 8 bits; fg/bg = FG_COLOR/BG_COLOR.

Decomposition:
- Package text_render_pkg holds:
  - TILE_W=8, FONT_ADDR_W=11.
  - Attribute field offsets/widths.
  - Phase constants PH_ADDR=1, PH_LATCH=3, PH_LOAD=7.
- One natural sub-module, tile_fetch: next-tile column/row computation, text_addr/blank/fetch_y registers, and the pending latch.
- The top level keeps the shifter and colour mux.

Test Plan:
- Char 'A' (0x41) at text RAM[0], vpos=0, hpos 0..7 -> font_addr=0x208 during prefetch phase 3 at hpos 315; rgb = 0,0,F,F,0,0,0,0 (glyph row 0x30).
- vpos=7, hpos 312..319 -> text_addr=32 (row 1, col 0); font_addr y=0; at vpos=8, hpos 0..7 shows row-1 glyph row 0.
- hpos 256..311 (ncol >= 32) -> blank fetches, rgb=BG_COLOR with display_on=1, text_addr unchanged.
- vpos=240 (row 30 >= ROWS) with RAM full of 0xDB -> rgb all BG.
- display_on=0 with non-blank glyphs -> rgb=0 every cycle.
- Reset pulse at hpos 100 -> rgb=0/BG immediately, text_addr=0; release at hpos 197 -> tile at hpos 200 blank, tile at hpos 208 correct.
- With ATTR_EN: text_data 0x1241 -> 'A' rendered fg=2, bg=1.
